// File: rtl/m3_sopc_reg_reader_if.sv
`default_nettype none
// ============================================================================
// Module      : m3_sopc_reg_reader_if
// Description : Bus bundle for m3_sopc_reg_reader. Carries the Avalon-MM read
//               master signals and the valid/ready output stream.
//               master modport : the register reader (drives avm_address,
//                                avm_read, out_data, out_valid, out_last)
//               slave modport  : the fabric plus the downstream sink (drives
//                                avm_waitrequest, avm_readdata,
//                                avm_readdatavalid, out_ready)
// Revision    : 1.0 - initial release
// ============================================================================
interface m3_sopc_reg_reader_if #(
    parameter int ADDR_W = 4
) ();
    logic [ADDR_W-1:0] avm_address;
    logic              avm_read;
    logic              avm_waitrequest;
    logic [31:0]       avm_readdata;
    logic              avm_readdatavalid;
    logic [31:0]       out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;

    modport master (
        output avm_address,
        output avm_read,
        input  avm_waitrequest,
        input  avm_readdata,
        input  avm_readdatavalid,
        output out_data,
        output out_valid,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  avm_address,
        input  avm_read,
        output avm_waitrequest,
        output avm_readdata,
        output avm_readdatavalid,
        input  out_data,
        input  out_valid,
        input  out_last,
        output out_ready
    );
endinterface
`default_nettype wire

// File: rtl/m3_sopc_reg_reader.sv
`default_nettype none
// ============================================================================
// Module      : m3_sopc_reg_reader
// Description : Avalon-MM read master. On start, reads WORDS consecutive
//               32-bit registers beginning at word address BASE, one read
//               outstanding at a time, and streams each word out over a
//               valid/ready interface. Supports waitrequest, fixed (RD_LAT>0)
//               or variable (RD_LAT=0, readdatavalid) latency, a per-word
//               timeout and downstream backpressure.
// Ports       : clk, reset_n (async, active-low)
//               start  - begin a sequence when idle
//               busy   - sequence in progress
//               done   - one-cycle pulse at sequence end (normal or aborted)
//               error  - sticky timeout flag, cleared by an accepted start
//               bus    - master modport: avm_* read port and out_* stream
// Revision    : 1.0 - initial release
// ============================================================================
module m3_sopc_reg_reader #(
    parameter int ADDR_W  = 4,
    parameter int BASE    = 0,
    parameter int WORDS   = 4,
    parameter int RD_LAT  = 1,
    parameter int TIMEOUT = 255
) (
    input  wire logic             clk,
    input  wire logic             reset_n,
    input  wire logic             start,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    m3_sopc_reg_reader_if.master  bus
);

    localparam int                IDX_W      = $clog2(WORDS + 1);
    localparam logic [ADDR_W-1:0] c_base     = ADDR_W'(BASE);
    localparam logic [IDX_W-1:0]  c_last_idx = IDX_W'(WORDS - 1);
    localparam logic [2:0]        c_lat_load = (RD_LAT > 0) ? 3'(RD_LAT - 1) : 3'd0;
    // Timeout fires on the edge where the counter would step to TIMEOUT.
    localparam logic [15:0]       c_to_last  = 16'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_OUT  = 3'd3,
        S_FIN  = 3'd4
    } state_t;

    state_t            r_state;
    logic              r_busy;
    logic              r_done;
    logic              r_error;
    logic              r_read;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_out_data;
    logic              r_out_valid;
    logic              r_out_last;
    logic [IDX_W-1:0]  r_idx;
    logic [2:0]        r_lat;
    logic [15:0]       r_to_cnt;

    logic              w_capture;
    logic              w_to_hit;

    // Fixed latency counts down from RD_LAT-1 loaded at acceptance; variable
    // latency waits for the slave's readdatavalid.
    always_comb begin
        w_capture = (RD_LAT == 0) ? bus.avm_readdatavalid : (r_lat == 3'd0);
        w_to_hit  = (r_to_cnt == c_to_last);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_read      <= 1'b0;
            r_addr      <= c_base;
            r_out_data  <= 32'd0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_idx       <= '0;
            r_lat       <= 3'd0;
            r_to_cnt    <= 16'd0;
        end else begin
            // done is only ever raised on the edge entering FIN.
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_idx  <= '0;
                    r_addr <= c_base;
                    if (start) begin
                        r_state  <= S_REQ;
                        r_busy   <= 1'b1;
                        r_error  <= 1'b0;
                        r_read   <= 1'b1;
                        r_to_cnt <= 16'd0;
                    end
                end
                S_REQ: begin
                    r_to_cnt <= r_to_cnt + 16'd1;
                    if (w_to_hit) begin
                        r_read  <= 1'b0;
                        r_error <= 1'b1;
                        r_done  <= 1'b1;
                        r_state <= S_FIN;
                    end else if (!bus.avm_waitrequest) begin
                        r_read  <= 1'b0;
                        r_lat   <= c_lat_load;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    r_to_cnt <= r_to_cnt + 16'd1;
                    // Data arriving on the final allowed cycle still counts.
                    if (w_capture) begin
                        r_out_data  <= bus.avm_readdata;
                        r_out_valid <= 1'b1;
                        r_out_last  <= (r_idx == c_last_idx);
                        r_state     <= S_OUT;
                    end else if (w_to_hit) begin
                        r_error <= 1'b1;
                        r_done  <= 1'b1;
                        r_state <= S_FIN;
                    end else begin
                        r_lat <= r_lat - 3'd1;
                    end
                end
                S_OUT: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_out_last  <= 1'b0;
                        if (r_idx == c_last_idx) begin
                            r_done  <= 1'b1;
                            r_state <= S_FIN;
                        end else begin
                            // Address tracks BASE+index; the increment wraps
                            // naturally at ADDR_W bits.
                            r_idx    <= r_idx + IDX_W'(1);
                            r_addr   <= r_addr + ADDR_W'(1);
                            r_read   <= 1'b1;
                            r_to_cnt <= 16'd0;
                            r_state  <= S_REQ;
                        end
                    end
                end
                S_FIN: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy            = r_busy;
    assign done            = r_done;
    assign error           = r_error;
    assign bus.avm_read    = r_read;
    assign bus.avm_address = r_addr;
    assign bus.out_data    = r_out_data;
    assign bus.out_valid   = r_out_valid;
    assign bus.out_last    = r_out_last;

endmodule
`default_nettype wire

// File: tb/tb_m3_sopc_reg_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_m3_sopc_reg_reader
// Description : Directed self-checking bench for m3_sopc_reg_reader.
//               Instance A: BASE=0 WORDS=4 RD_LAT=1 (normal, stall,
//               backpressure, reset mid-operation). Instance B: RD_LAT=0,
//               TIMEOUT=20 (timeout). Instance C: ADDR_W=2 BASE=3 WORDS=3
//               (address wrap, start while busy).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_m3_sopc_reg_reader;

    logic clk = 1'b0;
    logic reset_n;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic a_start, a_busy, a_done, a_error;
    logic b_start, b_busy, b_done, b_error;
    logic c_start, c_busy, c_done, c_error;

    m3_sopc_reg_reader_if #(.ADDR_W(4)) a_if ();
    m3_sopc_reg_reader_if #(.ADDR_W(4)) b_if ();
    m3_sopc_reg_reader_if #(.ADDR_W(2)) c_if ();

    m3_sopc_reg_reader #(.ADDR_W(4), .BASE(0), .WORDS(4), .RD_LAT(1), .TIMEOUT(255)) u_a (
        .clk(clk), .reset_n(reset_n), .start(a_start),
        .busy(a_busy), .done(a_done), .error(a_error), .bus(a_if.master));
    m3_sopc_reg_reader #(.ADDR_W(4), .BASE(0), .WORDS(4), .RD_LAT(0), .TIMEOUT(20)) u_b (
        .clk(clk), .reset_n(reset_n), .start(b_start),
        .busy(b_busy), .done(b_done), .error(b_error), .bus(b_if.master));
    m3_sopc_reg_reader #(.ADDR_W(2), .BASE(3), .WORDS(3), .RD_LAT(1), .TIMEOUT(255)) u_c (
        .clk(clk), .reset_n(reset_n), .start(c_start),
        .busy(c_busy), .done(c_done), .error(c_error), .bus(c_if.master));

    // ---------------- slave models: data = A5000000 + address, 1-cycle registered
    logic a_stall_en;
    int   a_stall_cnt = 0;
    logic b_drop;

    assign a_if.avm_waitrequest   = a_stall_en && a_if.avm_read &&
                                    (a_if.avm_address == 4'd1) && (a_stall_cnt < 5);
    assign a_if.avm_readdatavalid = 1'b0;
    assign b_if.avm_waitrequest   = 1'b0;
    assign c_if.avm_waitrequest   = 1'b0;
    assign c_if.avm_readdatavalid = 1'b0;

    always @(posedge clk) begin
        if (!a_stall_en)                a_stall_cnt <= 0;
        else if (a_if.avm_waitrequest)  a_stall_cnt <= a_stall_cnt + 1;
        if (a_if.avm_read && !a_if.avm_waitrequest)
            a_if.avm_readdata <= 32'hA500_0000 + 32'(a_if.avm_address);
        if (b_if.avm_read)
            b_if.avm_readdata <= 32'hA500_0000 + 32'(b_if.avm_address);
        b_if.avm_readdatavalid <= b_if.avm_read && !(b_drop && b_if.avm_address == 4'd2);
        if (c_if.avm_read)
            c_if.avm_readdata <= 32'hA500_0000 + 32'(c_if.avm_address);
    end

    // ---------------- monitors (sample on the falling edge)
    logic [31:0] a_words[$], a_addrs[$], b_words[$], b_addrs[$], c_words[$], c_addrs[$];
    logic        a_lasts[$];
    int          a_ndone, a_rd1, b_ndone, b_iss, b_done_cyc, c_ndone;

    always @(negedge clk) begin
        if (a_if.out_valid && a_if.out_ready) begin
            a_words.push_back(a_if.out_data);
            a_lasts.push_back(a_if.out_last);
        end
        if (a_if.avm_read && !a_if.avm_waitrequest) a_addrs.push_back(32'(a_if.avm_address));
        if (a_if.avm_read && a_if.avm_address == 4'd1) a_rd1 = a_rd1 + 1;
        if (a_done) a_ndone = a_ndone + 1;

        if (b_if.out_valid && b_if.out_ready) b_words.push_back(b_if.out_data);
        if (b_if.avm_read) b_addrs.push_back(32'(b_if.avm_address));
        if (b_if.avm_read && b_if.avm_address == 4'd2 && b_iss < 0) b_iss = cyc;
        if (b_done) begin b_ndone = b_ndone + 1; b_done_cyc = cyc; end

        if (c_if.out_valid && c_if.out_ready) c_words.push_back(c_if.out_data);
        if (c_if.avm_read) c_addrs.push_back(32'(c_if.avm_address));
        if (c_done) c_ndone = c_ndone + 1;
    end

    // ---------------- helpers
    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        a_words.delete(); a_addrs.delete(); a_lasts.delete();
        b_words.delete(); b_addrs.delete();
        c_words.delete(); c_addrs.delete();
        a_ndone = 0; a_rd1 = 0; b_ndone = 0; b_iss = -1; b_done_cyc = -1; c_ndone = 0;
    endtask

    function automatic logic done_of(input int w);
        case (w)
            0:       return a_done;
            1:       return b_done;
            default: return c_done;
        endcase
    endfunction

    // Leaves the caller at posedge+1 of the cycle after the sampling edge.
    task automatic pulse(input int w);
        @(posedge clk); #1;
        case (w) 0: a_start = 1'b1; 1: b_start = 1'b1; default: c_start = 1'b1; endcase
        @(posedge clk); #1;
        a_start = 1'b0; b_start = 1'b0; c_start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int w, input int budget, output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!done_of(w) && cycles < budget);
        check_eq(tag, 32'(done_of(w)), 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic check_a_seq(input string tag);
        check_eq({tag, "_nwords"}, a_words.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("%s_word%0d", tag, i), a_words[i], 32'hA500_0000 + i);
            check_eq($sformatf("%s_last%0d", tag, i), 32'(a_lasts[i]), (i == 3) ? 32'd1 : 32'd0);
            check_eq($sformatf("%s_addr%0d", tag, i), a_addrs[i], i);
        end
        check_eq({tag, "_ndone"}, a_ndone, 1);
        check_eq({tag, "_error"}, 32'(a_error), 0);
    endtask

    // ---------------- stimulus
    initial begin : stim
        int  cycles;
        int  guard;
        reset_n = 1'b0;
        a_start = 1'b0; b_start = 1'b0; c_start = 1'b0;
        a_stall_en = 1'b0; b_drop = 1'b0;
        a_if.out_ready = 1'b1; b_if.out_ready = 1'b1; c_if.out_ready = 1'b1;
        clear_logs();
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_busy",  32'(a_busy), 0);
        check_eq("rst_done",  32'(a_done), 0);
        check_eq("rst_error", 32'(a_error), 0);
        check_eq("rst_read",  32'(a_if.avm_read), 0);
        check_eq("rst_valid", 32'(a_if.out_valid), 0);
        check_eq("rst_last",  32'(a_if.out_last), 0);
        check_eq("rst_addr",  32'(a_if.avm_address), 0);
        check_eq("rst_data",  a_if.out_data, 0);
        check_eq("rst_c_addr", 32'(c_if.avm_address), 3);
        reset_n = 1'b1;

        // Normal read: 4 words, 3 cycles each, FIN on cycle 13.
        clear_logs();
        pulse(0);
        check_eq("norm_busy1", 32'(a_busy), 1);
        check_eq("norm_read1", 32'(a_if.avm_read), 1);
        wait_done("norm_done_seen", 0, 100, cycles);
        check_eq("norm_cycles", cycles, 13);
        check_eq("norm_busy_after", 32'(a_busy), 0);
        check_eq("norm_done_after", 32'(a_done), 0);
        check_a_seq("norm");

        // Waitrequest stall for 5 cycles on word 2.
        clear_logs();
        a_stall_en = 1'b1;
        pulse(0);
        wait_done("stall_done_seen", 0, 100, cycles);
        check_eq("stall_cycles", cycles, 18);
        check_eq("stall_rd_cycles", a_rd1, 6);
        check_a_seq("stall");
        a_stall_en = 1'b0;

        // Backpressure for 10 cycles on word 1.
        clear_logs();
        a_if.out_ready = 1'b0;
        pulse(0);
        guard = 0;
        do begin @(negedge clk); guard++; end while (!a_if.out_valid && guard < 20);
        for (int i = 0; i < 10; i++) begin
            check_eq($sformatf("bp_valid%0d", i), 32'(a_if.out_valid), 1);
            check_eq($sformatf("bp_data%0d", i), a_if.out_data, 32'hA500_0000);
            check_eq($sformatf("bp_noread%0d", i), 32'(a_if.avm_read), 0);
            if (i < 9) @(negedge clk);
        end
        @(posedge clk); #1;
        a_if.out_ready = 1'b1;
        wait_done("bp_done_seen", 0, 100, cycles);
        check_a_seq("bp");

        // Timeout on word 3 (instance B).
        clear_logs();
        b_drop = 1'b1;
        pulse(1);
        wait_done("to_done_seen", 1, 200, cycles);
        check_eq("to_nwords", b_words.size(), 2);
        check_eq("to_word0", b_words[0], 32'hA500_0000);
        check_eq("to_word1", b_words[1], 32'hA500_0001);
        check_eq("to_error", 32'(b_error), 1);
        check_eq("to_latency", b_done_cyc - b_iss, 20);
        check_eq("to_ndone", b_ndone, 1);
        b_drop = 1'b0;
        clear_logs();
        pulse(1);
        check_eq("to_err_clr", 32'(b_error), 0);
        wait_done("to2_done_seen", 1, 200, cycles);
        check_eq("to2_nwords", b_words.size(), 4);
        check_eq("to2_word3", b_words[3], 32'hA500_0003);
        check_eq("to2_error", 32'(b_error), 0);

        // Wrap and start-while-busy (instance C).
        clear_logs();
        pulse(2);
        check_eq("wrap_addr_first", 32'(c_if.avm_address), 3);
        repeat (3) @(posedge clk);
        pulse(2);
        wait_done("wrap_done_seen", 2, 100, cycles);
        repeat (6) @(posedge clk);
        #1;
        check_eq("wrap_naddr", c_addrs.size(), 3);
        check_eq("wrap_addr0", c_addrs[0], 3);
        check_eq("wrap_addr1", c_addrs[1], 0);
        check_eq("wrap_addr2", c_addrs[2], 1);
        check_eq("wrap_nwords", c_words.size(), 3);
        check_eq("wrap_word0", c_words[0], 32'hA500_0003);
        check_eq("wrap_word1", c_words[1], 32'hA500_0000);
        check_eq("wrap_word2", c_words[2], 32'hA500_0001);
        check_eq("wrap_ndone", c_ndone, 1);
        check_eq("wrap_idle", 32'(c_busy), 0);

        // Reset during WAIT of word 2 (instance A).
        clear_logs();
        pulse(0);
        guard = 0;
        do begin @(negedge clk); guard++; end
        while (!(a_if.avm_read && a_if.avm_address == 4'd1) && guard < 50);
        check_eq("mid_reached_word2", 32'(a_if.avm_address), 1);
        @(posedge clk); #2;
        reset_n = 1'b0;
        #1;
        check_eq("mid_busy",  32'(a_busy), 0);
        check_eq("mid_read",  32'(a_if.avm_read), 0);
        check_eq("mid_valid", 32'(a_if.out_valid), 0);
        check_eq("mid_last",  32'(a_if.out_last), 0);
        check_eq("mid_addr",  32'(a_if.avm_address), 0);
        check_eq("mid_data",  a_if.out_data, 0);
        check_eq("mid_done",  32'(a_done), 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        clear_logs();
        pulse(0);
        check_eq("post_addr_first", 32'(a_if.avm_address), 0);
        wait_done("post_done_seen", 0, 100, cycles);
        check_a_seq("post");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
